// File: rtl/hs_reg_pipeline_pkg.sv
// Shared types and helpers for the handshaked register pipeline.
// Holds the per-stage skid state encoding and the occupancy width rule.
package hs_reg_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Each stage holds up to two words, so the counter must reach 2*depth.
  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/hs_reg_stage.sv
// One two-entry skid register stage with a valid/ready handshake.
// Ready depends only on local state, so no ready path crosses the stage.
module hs_reg_stage
  import hs_reg_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rd
);

  stage_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic                  in_xfer;
  logic                  out_xfer;

  assign in_rd    = (state_q != ST_TWO);
  assign out_vld  = (state_q != ST_EMPTY);
  assign out_data = m_q;

  assign in_xfer  = in_vld & in_rd;
  assign out_xfer = out_vld & out_rd;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          m_d     = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_d = in_data;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          s_d     = in_data;
          state_d = ST_TWO;
        end
      end
      ST_TWO: begin
        // The skid word moves up to the head; ready reopens next cycle.
        if (out_xfer) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the data registers are
  // reset too because the output word must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/hs_reg_pipeline.sv
// DEPTH-stage handshaked delay line built from skid stages, with a word counter.
// Data and ready are both registered at every stage boundary.
module hs_reg_pipeline
  import hs_reg_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIn_data,
  input  logic                  dataIn_vld,
  output logic                  dataIn_rd,
  output logic [DATA_WIDTH-1:0] dataOut_data,
  output logic                  dataOut_vld,
  input  logic                  dataOut_rd,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  // Index k is the input side of stage k; index DEPTH is the block output.
  logic [DATA_WIDTH-1:0] data_w [DEPTH+1];
  logic                  vld_w  [DEPTH+1];
  logic                  rd_w   [DEPTH+1];

  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  in_xfer;
  logic                  out_xfer;

  assign data_w[0]    = dataIn_data;
  assign vld_w[0]     = dataIn_vld;
  assign dataIn_rd    = rst_n & rd_w[0];
  assign dataOut_data = data_w[DEPTH];
  assign dataOut_vld  = vld_w[DEPTH];
  assign rd_w[DEPTH]  = dataOut_rd;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    hs_reg_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (data_w[k]),
      .in_vld   (vld_w[k]),
      .in_rd    (rd_w[k]),
      .out_data (data_w[k+1]),
      .out_vld  (vld_w[k+1]),
      .out_rd   (rd_w[k+1])
    );
  end

  assign in_xfer  = dataIn_vld & dataIn_rd;
  assign out_xfer = dataOut_vld & dataOut_rd;

  always_comb begin
    occ_d = occ_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  occ_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= CNT_WIDTH'(2 * DEPTH));

endmodule

// File: tb/tb_hs_reg_pipeline.sv
// Self-checking bench for hs_reg_pipeline (DEPTH=2): directed latency, capacity
// and reset cases plus a randomised run, all checked against a word scoreboard.
module tb_hs_reg_pipeline;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(2 * DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] dataIn_data;
  logic          dataIn_vld;
  logic          dataIn_rd;
  logic [DW-1:0] dataOut_data;
  logic          dataOut_vld;
  logic          dataOut_rd;
  logic [CW-1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb_q[$];
  int            model_occ = 0;
  int            rx_count  = 0;

  always #5 clk = ~clk;

  hs_reg_pipeline #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataIn_data  (dataIn_data),
    .dataIn_vld   (dataIn_vld),
    .dataIn_rd    (dataIn_rd),
    .dataOut_data (dataOut_data),
    .dataOut_vld  (dataOut_vld),
    .dataOut_rd   (dataOut_rd),
    .occupancy    (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 200;
    while ((sb_q.size() != 0 || occupancy != '0) && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: inputs are stable from #1 after posedge until the next
  // posedge, so the negedge sees exactly what the next edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_rd_low", 32'(dataIn_rd), 32'd0);
      sb_q.delete();
      model_occ = 0;
    end else begin
      check("occupancy", 32'(occupancy), 32'(model_occ));
      if (dataIn_vld && dataIn_rd) begin
        sb_q.push_back(dataIn_data);
        model_occ++;
      end
      if (dataOut_vld && dataOut_rd) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious_out", 32'(dataOut_vld), 32'd0);
        end else begin
          check("sb_data", 32'(dataOut_data), 32'(sb_q.pop_front()));
          rx_count++;
        end
        model_occ--;
      end
    end
  end

  initial begin
    int acc;
    int sent;
    int rx_start;
    int budget;

    rst_n       = 1'b0;
    dataIn_data = '0;
    dataIn_vld  = 1'b0;
    dataOut_rd  = 1'b0;

    // Reset release.
    repeat (3) tick();
    check("rst_in_rd", 32'(dataIn_rd), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_rd", 32'(dataIn_rd), 32'd1);
    check("rel_out_vld", 32'(dataOut_vld), 32'd0);
    check("rel_out_data", 32'(dataOut_data), 32'd0);
    check("rel_occ", 32'(occupancy), 32'd0);

    // Single word latency.
    dataIn_data = 8'hA5;
    dataIn_vld  = 1'b1;
    dataOut_rd  = 1'b1;
    tick();
    dataIn_vld = 1'b0;
    check("single_t1_vld", 32'(dataOut_vld), 32'd0);
    check("single_t1_occ", 32'(occupancy), 32'd1);
    tick();
    check("single_t2_vld", 32'(dataOut_vld), 32'd1);
    check("single_t2_data", 32'(dataOut_data), 32'hA5);
    tick();
    check("single_t3_vld", 32'(dataOut_vld), 32'd0);
    check("single_t3_occ", 32'(occupancy), 32'd0);

    // Back-to-back stream with no bubbles after the initial latency.
    for (int k = 0; k < 20; k++) begin
      dataIn_vld  = (k < 16);
      dataIn_data = DW'(k);
      if (k < 16) check("stream_in_rd", 32'(dataIn_rd), 32'd1);
      check("stream_vld", 32'(dataOut_vld), 32'((k >= DEPTH) && (k < 16 + DEPTH)));
      if (k >= DEPTH && k < 16 + DEPTH) check("stream_data", 32'(dataOut_data), 32'(k - DEPTH));
      tick();
    end
    dataIn_vld = 1'b0;

    // Capacity under backpressure, then drain.
    dataOut_rd = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      dataIn_vld  = 1'b1;
      dataIn_data = DW'(8'h40 + acc);
      if (dataIn_rd) acc++;
      tick();
    end
    dataIn_vld = 1'b0;
    check("full_accepted", 32'(acc), 32'(2 * DEPTH));
    check("full_in_rd", 32'(dataIn_rd), 32'd0);
    check("full_occ", 32'(occupancy), 32'(2 * DEPTH));
    dataOut_rd = 1'b1;
    for (int c = 0; c < DEPTH && !dataIn_rd; c++) tick();
    check("drain_in_rd_return", 32'(dataIn_rd), 32'd1);
    wait_drain("full_drain");

    // Random valid/ready, 1000 words.
    sent     = 0;
    rx_start = rx_count;
    budget   = 20000;
    while (sent < 1000 && budget > 0) begin
      dataIn_vld  = $urandom_range(0, 1) != 0;
      dataIn_data = DW'($urandom);
      dataOut_rd  = $urandom_range(0, 1) != 0;
      if (dataIn_vld && dataIn_rd) sent++;
      tick();
      budget--;
    end
    check("rand_sent", 32'(sent), 32'd1000);
    dataIn_vld = 1'b0;
    dataOut_rd = 1'b1;
    wait_drain("rand_drain");
    check("rand_rx_count", 32'(rx_count - rx_start), 32'd1000);

    // Mid-stream reset discards held words.
    dataOut_rd = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dataIn_vld  = 1'b1;
      dataIn_data = DW'(8'hE0 + c);
      tick();
    end
    dataIn_vld = 1'b0;
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_occ", 32'(occupancy), 32'd0);
    check("post_rst_vld", 32'(dataOut_vld), 32'd0);
    check("post_rst_data", 32'(dataOut_data), 32'd0);
    rx_start   = rx_count;
    dataOut_rd = 1'b1;
    dataIn_vld = 1'b1;
    dataIn_data = 8'h11;
    tick();
    dataIn_data = 8'h22;
    tick();
    dataIn_vld = 1'b0;
    check("post_rst_first", 32'(dataOut_data), 32'h11);
    wait_drain("post_rst_drain");
    check("post_rst_rx", 32'(rx_count - rx_start), 32'd2);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
